// File: rtl/fetch_pkg.sv
// Shared fetch definitions: memory access encodings, default start PC,
// fetch FSM state type and a saturating adder for statistics counters.
package fetch_pkg;

  localparam logic [1:0] ACCESS_1W  = 2'b00;
  localparam logic [1:0] ACCESS_4W  = 2'b01;
  localparam logic [1:0] ACCESS_8W  = 2'b10;
  localparam logic [1:0] ACCESS_16W = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  localparam logic [31:0] DEFAULT_START_ADDR = 32'h8002_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[32]) begin
      return 32'hFFFF_FFFF;
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with a synchronous flush that wins over push/pop.
// Head data reads as zero while empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop & (count_r != CW'(0));
  assign do_push_s = push & ((count_r != CW'(DEPTH)) | do_pop_s);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are masked at the output while empty.
  always_ff @(posedge clock) begin
    if (do_push_s && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Show-ahead head presentation.
  always_comb begin
    head_data = '0;
    if (count_r != CW'(0)) begin
      head_data = mem_r[rd_ptr_r];
    end else begin
      head_data = '0;
    end
  end

  assign head_valid = (count_r != CW'(0));
  assign count      = count_r;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation, credit-limited issue,
// latency tracker and decode queue. Optional counters under FETCH_QUEUE_STATS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    DEPTH        = 4,
  parameter int                    READ_LATENCY = 1,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR   = ADDR_WIDTH'(DEFAULT_START_ADDR),
  localparam int                   OCC_W        = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable_fetch,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_enable,
  output logic                  mem_rw,
  output logic [1:0]            mem_access_size,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic [DATA_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [OCC_W-1:0]      occupancy
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [31:0]           stat_fetched,
  output logic [31:0]           stat_stall,
  output logic [31:0]           stat_squashed
`endif
);

  localparam int SUM_W = $clog2(DEPTH + READ_LATENCY + 1);

  fetch_state_e            state_r;
  fetch_state_e            state_nxt_s;
  logic [ADDR_WIDTH-1:0]   fetch_pc_r;
  logic [READ_LATENCY-1:0] trk_vld_r;
  logic [ADDR_WIDTH-1:0]   trk_tag_r [READ_LATENCY];
  logic [SUM_W-1:0]        inflight_s;
  logic [SUM_W-1:0]        credit_used_s;
  logic                    has_credit_s;
  logic                    issue_s;
  logic                    push_s;
  logic                    pop_s;
  logic [OCC_W-1:0]        occ_s;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] head_s;

  // Count requests still travelling through the latency tracker.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight_s = inflight_s + SUM_W'(trk_vld_r[i]);
    end
  end

  assign credit_used_s = SUM_W'(occ_s) + inflight_s;
  assign has_credit_s  = credit_used_s < SUM_W'(DEPTH);
  assign issue_s       = enable_fetch & ~mem_busy & ~redirect & has_credit_s;
  assign push_s        = trk_vld_r[READ_LATENCY-1] & ~redirect;
  assign pop_s         = insn_valid & insn_ready & ~redirect;

  // Next-state selection from current inputs and credit.
  always_comb begin
    state_nxt_s = state_r;
    if (redirect) begin
      state_nxt_s = enable_fetch ? ST_ISSUE : ST_IDLE;
    end else if (!enable_fetch) begin
      state_nxt_s = ST_IDLE;
    end else if (mem_busy || !has_credit_s) begin
      state_nxt_s = ST_WAIT;
    end else begin
      state_nxt_s = ST_ISSUE;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Fetch PC: redirect target is word aligned; a held request keeps its address.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_r <= START_ADDR;
    end else if (redirect) begin
      fetch_pc_r <= redirect_pc & ~ADDR_WIDTH'(3);
    end else if (issue_s) begin
      fetch_pc_r <= fetch_pc_r + ADDR_WIDTH'(4);
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // Latency tracker; redirect kills every outstanding request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      trk_vld_r <= '0;
      for (int i = 0; i < READ_LATENCY; i++) trk_tag_r[i] <= '0;
    end else begin
      trk_tag_r[0] <= fetch_pc_r;
      for (int i = 1; i < READ_LATENCY; i++) trk_tag_r[i] <= trk_tag_r[i-1];
      if (redirect) begin
        trk_vld_r <= '0;
      end else begin
        trk_vld_r[0] <= issue_s;
        for (int i = 1; i < READ_LATENCY; i++) trk_vld_r[i] <= trk_vld_r[i-1];
      end
    end
  end

  sync_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock      (clock),
    .reset_n    (reset_n),
    .flush      (redirect),
    .push       (push_s),
    .push_data  ({trk_tag_r[READ_LATENCY-1], mem_data_out}),
    .pop        (pop_s),
    .head_data  (head_s),
    .head_valid (insn_valid),
    .count      (occ_s)
  );

  assign pc              = head_s[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign insn            = head_s[DATA_WIDTH-1:0];
  assign occupancy       = occ_s;
  assign mem_address     = fetch_pc_r;
  assign mem_enable      = issue_s;
  assign mem_rw          = RW_READ;
  assign mem_access_size = ACCESS_1W;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stat_fetched_r;
  logic [31:0] stat_stall_r;
  logic [31:0] stat_squashed_r;

  // Saturating activity counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_fetched_r  <= 32'd0;
      stat_stall_r    <= 32'd0;
      stat_squashed_r <= 32'd0;
    end else begin
      stat_fetched_r  <= sat_add32(stat_fetched_r, {31'd0, push_s});
      stat_stall_r    <= sat_add32(stat_stall_r, {31'd0, (state_r == ST_WAIT)});
      stat_squashed_r <= redirect ? sat_add32(stat_squashed_r, 32'(credit_used_s))
                                  : stat_squashed_r;
    end
  end

  assign stat_fetched  = stat_fetched_r;
  assign stat_stall    = stat_stall_r;
  assign stat_squashed = stat_squashed_r;
`endif

endmodule
